// File: rtl/formula_witness_gen_if.sv
// Request/response bundle for formula_witness_gen.
// The master is the example-driver side: it issues x assignments and
// consumes the resulting witness vectors.
// The slave is the generator itself.
interface formula_witness_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  x_vec;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] i_vec;
    logic        sat;
    logic        conv;
    logic [3:0]  iters;

    modport master (
        output in_valid,
        output x_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  i_vec,
        input  sat,
        input  conv,
        input  iters
    );

    modport slave (
        input  in_valid,
        input  x_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output i_vec,
        output sat,
        output conv,
        output iters
    );
endinterface

// File: rtl/formula_witness_gen.sv
// Sequential witness generator for the 7-input / 12-output adder-and-latch
// relation. For a latched x assignment it resolves the acyclic outputs,
// iterates the cyclic i_10/i_11/i_12 chain to its least fixed point, and
// finally re-evaluates the whole relation so the consumer gets a sat flag
// alongside the witness.
// The clause evaluation is split over two CHECK cycles. The first cycle
// registers the seven clause equalities. The second reduces them to sat and
// raises out_valid. This keeps the relation logic away from the handshake
// flops.
module formula_witness_gen #(
    parameter int unsigned MAX_ITER = 4,
    parameter bit          I9_VALUE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    formula_witness_gen_if.slave bus
);

    localparam logic [3:0] MaxIterW = 4'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE,
        ACYC,
        ITER,
        CHECK,
        DONE
    } state_t;

    state_t      state_q;
    logic        checkPhase_q;
    logic        inReady_q;
    logic        outValid_q;
    logic        x0_q;
    logic        x4_q;
    logic        x5_q;
    logic        x6_q;
    logic [11:0] iVec_q;
    logic [6:0]  clauses_q;
    logic        sat_q;
    logic        conv_q;
    logic [3:0]  iters_q;

    logic        carry1;
    logic        acycI3;
    logic        acycI7;
    logic        acycI8;
    logic [11:0] acycVec;
    logic        i10_d;
    logic        i11_d;
    logic        i12_d;
    logic        cycChanged;
    logic [3:0]  itersNext;
    logic [6:0]  clauses_d;

    // Acyclic outputs: a half adder on x_0/x_5 feeding a full adder with x_4/x_6.
    always_comb begin
        carry1     = x0_q & x5_q;
        acycI7     = x0_q ^ x5_q;
        acycI8     = carry1 ^ x4_q ^ x6_q;
        acycI3     = (x4_q & x6_q) | (carry1 & (x4_q ^ x6_q));
        acycVec    = '0;
        acycVec[0] = ~I9_VALUE;
        acycVec[2] = acycI3;
        acycVec[6] = acycI7;
        acycVec[7] = acycI8;
        acycVec[8] = I9_VALUE;
    end

    // One Jacobi step of the cyclic chain, computed entirely from the old values.
    always_comb begin
        i10_d      = x0_q | iVec_q[11];
        i11_d      = x4_q & iVec_q[9];
        i12_d      = x5_q | iVec_q[10];
        cycChanged = (i10_d != iVec_q[9]) || (i11_d != iVec_q[10]) ||
                     (i12_d != iVec_q[11]);
        itersNext  = iters_q + 4'd1;
    end

    // The seven clause equalities of the relation on the registered witness.
    always_comb begin
        clauses_d    = '0;
        clauses_d[0] = (iVec_q[6] == (x0_q ^ x5_q));
        clauses_d[1] = (iVec_q[7] == ((x0_q & x5_q) ^ x4_q ^ x6_q));
        clauses_d[2] = (iVec_q[2] == ((x4_q & x6_q) |
                                     ((x0_q & x5_q) & (x4_q ^ x6_q))));
        clauses_d[3] = (iVec_q[0] == ~iVec_q[8]);
        clauses_d[4] = (iVec_q[9]  == (x0_q | iVec_q[11]));
        clauses_d[5] = (iVec_q[10] == (x4_q & iVec_q[9]));
        clauses_d[6] = (iVec_q[11] == (x5_q | iVec_q[10]));
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            checkPhase_q <= 1'b0;
            inReady_q    <= 1'b1;
            outValid_q   <= 1'b0;
            x0_q         <= 1'b0;
            x4_q         <= 1'b0;
            x5_q         <= 1'b0;
            x6_q         <= 1'b0;
            iVec_q       <= '0;
            clauses_q    <= '0;
            sat_q        <= 1'b0;
            conv_q       <= 1'b0;
            iters_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x0_q      <= bus.x_vec[0];
                        x4_q      <= bus.x_vec[4];
                        x5_q      <= bus.x_vec[5];
                        x6_q      <= bus.x_vec[6];
                        inReady_q <= 1'b0;
                        state_q   <= ACYC;
                    end
                end
                ACYC: begin
                    iVec_q  <= acycVec;
                    iters_q <= '0;
                    conv_q  <= 1'b0;
                    sat_q   <= 1'b0;
                    state_q <= ITER;
                end
                ITER: begin
                    iters_q <= itersNext;
                    if (!cycChanged) begin
                        conv_q       <= 1'b1;
                        checkPhase_q <= 1'b0;
                        state_q      <= CHECK;
                    end else begin
                        iVec_q[9]  <= i10_d;
                        iVec_q[10] <= i11_d;
                        iVec_q[11] <= i12_d;
                        if (itersNext == MaxIterW) begin
                            conv_q       <= 1'b0;
                            checkPhase_q <= 1'b0;
                            state_q      <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (!checkPhase_q) begin
                        clauses_q    <= clauses_d;
                        checkPhase_q <= 1'b1;
                    end else begin
                        sat_q        <= &clauses_q;
                        checkPhase_q <= 1'b0;
                        outValid_q   <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.i_vec     = iVec_q;
    assign bus.sat       = sat_q;
    assign bus.conv      = conv_q;
    assign bus.iters     = iters_q;

endmodule

// File: tb/tb_formula_witness_gen.sv
// Bench for formula_witness_gen.
// Two instances are driven through a shared stimulus path:
//   dutA uses MAX_ITER=4.
//   dutB uses MAX_ITER=2.
// Results are compared against a behavioural model of the relation. In that
// model the adder outputs come from integer sums, and the cyclic chain is
// iterated over an array of i values.
module tb_formula_witness_gen;

    typedef struct {
        logic [11:0] ivec;
        bit          sat;
        bit          conv;
        int          iters;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic       reqValid = 1'b0;
    logic [6:0] reqX = '0;
    logic       rspReady = 1'b0;
    bit         dutSel = 1'b0;
    int         acceptCyc = 0;
    int         releaseCyc = 0;
    logic [11:0] lastIvec = '0;
    bit          lastConv = 1'b0;
    bit          lastSat = 1'b0;

    formula_witness_gen_if ifA ();
    formula_witness_gen_if ifB ();

    assign ifA.in_valid  = reqValid & ~dutSel;
    assign ifB.in_valid  = reqValid & dutSel;
    assign ifA.x_vec     = reqX;
    assign ifB.x_vec     = reqX;
    assign ifA.out_ready = rspReady & ~dutSel;
    assign ifB.out_ready = rspReady & dutSel;

    formula_witness_gen #(.MAX_ITER(4), .I9_VALUE(1'b0)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    formula_witness_gen #(.MAX_ITER(2), .I9_VALUE(1'b0)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    logic        selInReady;
    logic        selOutValid;
    logic [11:0] selIvec;
    logic        selSat;
    logic        selConv;
    logic [3:0]  selIters;

    assign selInReady  = dutSel ? ifB.in_ready  : ifA.in_ready;
    assign selOutValid = dutSel ? ifB.out_valid : ifA.out_valid;
    assign selIvec     = dutSel ? ifB.i_vec     : ifA.i_vec;
    assign selSat      = dutSel ? ifB.sat       : ifA.sat;
    assign selConv     = dutSel ? ifB.conv      : ifA.conv;
    assign selIters    = dutSel ? ifB.iters     : ifA.iters;

    // Reference: adder outputs from integer sums, then least fixed point of the chain.
    function automatic result_t modelRun(input logic [6:0] x, input int maxIter, input bit i9);
        result_t r;
        int i [1:12];
        int a;
        int b;
        int c;
        int d;
        int s;
        int n10;
        int n11;
        int n12;
        bit ok;
        a = int'(x[0]);
        b = int'(x[4]);
        c = int'(x[5]);
        d = int'(x[6]);
        for (int k = 1; k <= 12; k++) i[k] = 0;
        i[7] = (a + c) % 2;
        s    = ((a + c) / 2) + b + d;
        i[8] = s % 2;
        i[3] = s / 2;
        i[9] = int'(i9);
        i[1] = 1 - int'(i9);
        r.conv  = 1'b0;
        r.iters = 0;
        for (int k = 1; k <= maxIter; k++) begin
            n10 = (a + i[12] > 0) ? 1 : 0;
            n11 = b * i[10];
            n12 = (c + i[11] > 0) ? 1 : 0;
            r.iters = k;
            if (n10 == i[10] && n11 == i[11] && n12 == i[12]) begin
                r.conv = 1'b1;
                break;
            end
            i[10] = n10;
            i[11] = n11;
            i[12] = n12;
        end
        ok = (i[7] == (a + c) % 2) &&
             (i[8] == (((a + c) / 2) + b + d) % 2) &&
             (i[3] == (((a + c) / 2) + b + d) / 2) &&
             (i[1] + i[9] == 1) &&
             (i[10] == ((a + i[12] > 0) ? 1 : 0)) &&
             (i[11] == b * i[10]) &&
             (i[12] == ((c + i[11] > 0) ? 1 : 0));
        r.sat = ok;
        for (int k = 1; k <= 12; k++) r.ivec[k-1] = (i[k] != 0);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sendRequest(input logic [6:0] x, input bit pending, output bit ok);
        bit rdy;
        ok       = 1'b0;
        reqX     = x;
        reqValid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = selInReady;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        reqValid = 1'b0;
        if (!ok) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else begin
            acceptCyc = cyc;
            if (pending) checkOutput("pending_accept_edge", acceptCyc, releaseCyc + 1);
            checkOutput("in_ready_busy", {31'd0, selInReady}, 32'd0);
        end
    endtask

    task automatic waitResult(input result_t exp, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (selOutValid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("result_timeout", 32'd0, 32'd1);
        end else begin
            lastIvec = selIvec;
            lastConv = selConv;
            lastSat  = selSat;
            checkOutput("latency", cyc - acceptCyc, exp.iters + 3);
            checkOutput("i_vec", {20'd0, selIvec}, {20'd0, exp.ivec});
            checkOutput("sat", {31'd0, selSat}, {31'd0, exp.sat});
            checkOutput("conv", {31'd0, selConv}, {31'd0, exp.conv});
            checkOutput("iters", {28'd0, selIters}, exp.iters);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [6:0] x, input int hold,
                                 input bit pending, input bit preloadNext, input logic [6:0] nextX);
        result_t exp;
        bit ok;
        dutSel = sel;
        exp = modelRun(x, sel ? 2 : 4, 1'b0);
        if (!pending) checkOutput("in_ready_idle", {31'd0, selInReady}, 32'd1);
        sendRequest(x, pending, ok);
        if (ok) waitResult(exp, ok);
        if (ok) begin
            if (preloadNext) begin
                reqX     = nextX;
                reqValid = 1'b1;
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                checkOutput("hold_out_valid", {31'd0, selOutValid}, 32'd1);
                checkOutput("hold_i_vec", {20'd0, selIvec}, {20'd0, exp.ivec});
                checkOutput("hold_flags", {28'd0, selSat, selConv, 2'd0} | {28'd0, selIters},
                            {28'd0, exp.sat, exp.conv, 2'd0} | exp.iters);
                checkOutput("hold_in_ready", {31'd0, selInReady}, 32'd0);
            end
            rspReady = 1'b1;
            @(posedge clk);
            #1;
            rspReady   = 1'b0;
            releaseCyc = cyc;
            checkOutput("release_out_valid", {31'd0, selOutValid}, 32'd0);
            checkOutput("release_in_ready", {31'd0, selInReady}, 32'd1);
        end
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_out_valid"}, {31'd0, ifA.out_valid}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, ifA.in_ready}, 32'd1);
        checkOutput({tag, "_i_vec"}, {20'd0, ifA.i_vec}, 32'd0);
        checkOutput({tag, "_flags"}, {26'd0, ifA.sat, ifA.conv, ifA.iters}, 32'd0);
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence: reset, directed spec cases, backpressure, random, resets.
    initial begin
        bit ok;
        logic [6:0] rx;
        bit rsel;
        int rhold;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetChecks("por");
        checkOutput("por_b_in_ready", {31'd0, ifB.in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 7'h00, 0, 1'b0, 1'b0, 7'h00);
        checkOutput("spec_zero_ivec", {20'd0, lastIvec}, 32'h001);
        applyStimulus(1'b0, 7'h21, 0, 1'b0, 1'b0, 7'h00);
        checkOutput("spec_a81_ivec", {20'd0, lastIvec}, 32'hA81);
        applyStimulus(1'b0, 7'h70, 0, 1'b0, 1'b0, 7'h00);
        checkOutput("spec_e45_ivec", {20'd0, lastIvec}, 32'hE45);
        applyStimulus(1'b1, 7'h70, 1, 1'b0, 1'b0, 7'h00);
        checkOutput("spec_a45_ivec", {20'd0, lastIvec}, 32'hA45);
        checkOutput("spec_a45_conv_sat", {30'd0, lastConv, lastSat}, 32'd0);

        applyStimulus(1'b0, 7'h21, 10, 1'b0, 1'b1, 7'h70);
        applyStimulus(1'b0, 7'h70, 0, 1'b1, 1'b0, 7'h00);

        for (int n = 0; n < 30; n++) begin
            rx    = 7'($urandom);
            rsel  = 1'($urandom_range(0, 1));
            rhold = $urandom_range(0, 3);
            applyStimulus(rsel, rx, rhold, 1'b0, 1'b0, 7'h00);
        end

        dutSel = 1'b0;
        sendRequest(7'h70, 1'b0, ok);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        resetChecks("rst_iter");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        sendRequest(7'h21, 1'b0, ok);
        for (int n = 0; n < 20 && !ifA.out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_rst_done_valid", {31'd0, ifA.out_valid}, 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        resetChecks("rst_done");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 7'h70, 0, 1'b0, 1'b0, 7'h00);
        checkOutput("post_rst_ivec", {20'd0, lastIvec}, 32'hE45);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
